// File: rtl/pipe_mon_pkg.sv
// ---------------------------------------------------------------------------
// pipe_mon_pkg
// Shared constants for the pipeline performance monitor:
//   - counter index map used by the cnt_sel readout mux
//   - trace entry layout {pc, r_d_a, w, res} (MSB to LSB)
//   - full-trace policy encodings
// ---------------------------------------------------------------------------
package pipe_mon_pkg;

   // Counter index map: 0 = cycles, 1 = retired, 2+s = bubbles of stage s
   localparam int CNT_CYCLES      = 0;
   localparam int CNT_RETIRED     = 1;
   localparam int CNT_BUBBLE_BASE = 2;

   // Full-trace policy
   localparam int TRACE_STOP = 0;   // drop the new entry
   localparam int TRACE_WRAP = 1;   // overwrite the oldest entry

   // Fixed-width trace fields
   localparam int RDA_W = 5;
   localparam int WEN_W = 1;

   // Trace entry field offsets, derived from the parametrised widths
   function automatic int trace_res_lsb();
      return 0;
   endfunction

   function automatic int trace_w_bit(input int data_w);
      return data_w;
   endfunction

   function automatic int trace_rda_lsb(input int data_w);
      return data_w + WEN_W;
   endfunction

   function automatic int trace_pc_lsb(input int data_w);
      return data_w + WEN_W + RDA_W;
   endfunction

   function automatic int trace_width(input int pc_w, input int data_w);
      return pc_w + data_w + WEN_W + RDA_W;
   endfunction

endpackage

// File: rtl/trace_ring_fifo.sv
// ---------------------------------------------------------------------------
// trace_ring_fifo
// Power-of-two ring buffer holding retired-instruction trace entries.
// Pops are registered: a successful pop presents the oldest entry on
// rd_data_o with rd_valid_o high for exactly one cycle. When full, a push
// without a pop is either dropped (TRACE_STOP) or overwrites the oldest
// entry (TRACE_WRAP); both set the sticky overflow flag.
// Ports:
//   clk_i, reset_i   clock, asynchronous active-high reset
//   clr_i            synchronous clear of contents and overflow flag
//   push_i           push request, push_data_i entry to store
//   pop_i            pop request
//   rd_valid_o       rd_data_o holds a freshly popped entry
//   rd_data_o        last popped entry
//   count_o          occupancy, 0..DEPTH
//   overflow_o       sticky: an entry was dropped or overwritten
// ---------------------------------------------------------------------------
module trace_ring_fifo
   import pipe_mon_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 70,
   parameter int MODE  = TRACE_STOP
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       clr_i,
   input  logic                       push_i,
   input  logic [WIDTH-1:0]           push_data_i,
   input  logic                       pop_i,
   output logic                       rd_valid_o,
   output logic [WIDTH-1:0]           rd_data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;

   logic empty, full;
   logic do_pop, push_full, overwrite, write_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == OCC_W'(DEPTH));

   // No bypass: a pop on an empty buffer is ignored even if a push arrives
   assign do_pop    = pop_i & ~empty & ~clr_i;
   // Push into a full buffer that no pop is making room for
   assign push_full = push_i & ~clr_i & full & ~do_pop;
   assign overwrite = push_full & (MODE == TRACE_WRAP);
   assign write_en  = push_i & ~clr_i & (~full | do_pop | overwrite);

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;
      if (clr_i) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (write_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         // Overwrite when full: write and read pointers coincide, so the
         // read pointer moves past the entry being replaced.
         if (do_pop | overwrite) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_q[rd_ptr_q];
         end
         if (write_en & ~do_pop & ~overwrite) begin
            count_d = count_q + OCC_W'(1);
         end else if (do_pop & ~write_en) begin
            count_d = count_q - OCC_W'(1);
         end
         if (push_full) begin
            overflow_d = 1'b1;
         end
      end
   end

   // Storage has no reset; only written slots are ever read
   always_ff @(posedge clk_i) begin
      if (write_en) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid_o = rd_valid_q;
   assign rd_data_o  = rd_data_q;
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/pipe_perf_monitor.sv
// ---------------------------------------------------------------------------
// pipe_perf_monitor
// Read-only observer beside the processor pipeline. Keeps saturating
// performance counters (cycles, retired instructions, per-stage bubbles)
// and a ring-buffer trace of retired instructions drained by a pop
// handshake.
// Ports:
//   clk_i, reset_i        clock, asynchronous active-high reset
//   enable_i              event sampling enable (pops work regardless)
//   clr_i                 synchronous clear of counters, trace, overflow
//   stage_nop_i           per-stage bubble flags, MSB stage is write-back
//   wb_pc_i, wb_w_i,
//   wb_r_d_a_i, wb_res_i  write-back bus captured into the trace
//   cnt_sel_i             0 cycles, 1 retired, 2+s bubbles of stage s
//   cnt_data_o            registered selected counter (0 if out of range)
//   trace_rd_en_i         pop request
//   trace_rd_valid_o      trace_rd_data_o valid this cycle
//   trace_rd_data_o       {pc, r_d_a, w, res}
//   trace_count_o         trace occupancy
//   trace_overflow_o      sticky dropped/overwritten flag
// ---------------------------------------------------------------------------
module pipe_perf_monitor
   import pipe_mon_pkg::*;
#(
   parameter int NUM_STAGES  = 5,
   parameter int PC_W        = 32,
   parameter int DATA_W      = 32,
   parameter int CNT_W       = 32,
   parameter int TRACE_DEPTH = 16,
   parameter int TRACE_MODE  = TRACE_STOP
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic                              enable_i,
   input  logic                              clr_i,
   input  logic [NUM_STAGES-1:0]             stage_nop_i,
   input  logic [PC_W-1:0]                   wb_pc_i,
   input  logic                              wb_w_i,
   input  logic [4:0]                        wb_r_d_a_i,
   input  logic [DATA_W-1:0]                 wb_res_i,
   input  logic [$clog2(NUM_STAGES+2)-1:0]   cnt_sel_i,
   output logic [CNT_W-1:0]                  cnt_data_o,
   input  logic                              trace_rd_en_i,
   output logic                              trace_rd_valid_o,
   output logic [PC_W+DATA_W+5:0]            trace_rd_data_o,
   output logic [$clog2(TRACE_DEPTH):0]      trace_count_o,
   output logic                              trace_overflow_o
);

   localparam int NUM_CNT = NUM_STAGES + 2;
   localparam int ENTRY_W = trace_width(PC_W, DATA_W);
   localparam int RES_LSB = trace_res_lsb();
   localparam int W_BIT   = trace_w_bit(DATA_W);
   localparam int RDA_LSB = trace_rda_lsb(DATA_W);
   localparam int PC_LSB  = trace_pc_lsb(DATA_W);

   logic [CNT_W-1:0]   cnt_val [NUM_CNT];
   logic [CNT_W-1:0]   cnt_data_q, cnt_data_d;
   logic [ENTRY_W-1:0] trace_entry;
   logic               trace_push;

   // ------------------------------------------------------------------
   // Counter array: one saturating counter per event source
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
         logic             ev;
         logic [CNT_W-1:0] c_q, c_d;

         if (gi == CNT_CYCLES) begin : g_ev_cycle
            assign ev = 1'b1;
         end else if (gi == CNT_RETIRED) begin : g_ev_retired
            assign ev = ~stage_nop_i[NUM_STAGES-1];
         end else begin : g_ev_bubble
            assign ev = stage_nop_i[gi-CNT_BUBBLE_BASE];
         end

         always_comb begin
            c_d = c_q;
            if (clr_i) begin
               c_d = '0;
            end else if (enable_i && ev && (c_q != '1)) begin
               c_d = c_q + CNT_W'(1);
            end
         end

         always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
               c_q <= '0;
            end else begin
               c_q <= c_d;
            end
         end

         assign cnt_val[gi] = c_q;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Readout mux; selects beyond the counter array read as zero
   // ------------------------------------------------------------------
   always_comb begin
      cnt_data_d = '0;
      for (int i = 0; i < NUM_CNT; i++) begin
         if (int'(cnt_sel_i) == i) begin
            cnt_data_d = cnt_val[i];
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnt_data_q <= '0;
      end else begin
         cnt_data_q <= cnt_data_d;
      end
   end

   assign cnt_data_o = cnt_data_q;

   // ------------------------------------------------------------------
   // Trace capture of every retirement
   // ------------------------------------------------------------------
   always_comb begin
      trace_entry = '0;
      trace_entry[RES_LSB +: DATA_W] = wb_res_i;
      trace_entry[W_BIT]             = wb_w_i;
      trace_entry[RDA_LSB +: RDA_W]  = wb_r_d_a_i;
      trace_entry[PC_LSB +: PC_W]    = wb_pc_i;
   end

   assign trace_push = enable_i & ~clr_i & ~stage_nop_i[NUM_STAGES-1];

   trace_ring_fifo #(
      .DEPTH (TRACE_DEPTH),
      .WIDTH (ENTRY_W),
      .MODE  (TRACE_MODE)
   ) u_trace (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clr_i       (clr_i),
      .push_i      (trace_push),
      .push_data_i (trace_entry),
      .pop_i       (trace_rd_en_i),
      .rd_valid_o  (trace_rd_valid_o),
      .rd_data_o   (trace_rd_data_o),
      .count_o     (trace_count_o),
      .overflow_o  (trace_overflow_o)
   );

endmodule
